// File: rtl/if_fetch_pkg.sv
// Shared types and constants for the instruction-fetch front end.
// Holds bus widths, the fetch FSM encoding, the PC step and the FIFO entry layout.
package if_fetch_pkg;

    localparam int unsigned INST_ADDR_W = 32;
    localparam int unsigned INST_W      = 32;

    localparam logic [INST_ADDR_W-1:0] PC_STEP   = 32'd4;
    localparam logic [INST_W-1:0]      ZERO_WORD = '0;

    typedef enum logic [1:0] {
        FETCH_IDLE    = 2'd0,
        FETCH_WAIT    = 2'd1,
        FETCH_DISCARD = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [INST_ADDR_W-1:0] pc;
        logic [INST_W-1:0]      inst;
    } fetch_entry_t;

endpackage

// File: rtl/if_fetch_fifo.sv
// Two-entry {pc, inst} fetch buffer; entry0 is always the head.
// Flush wins over push/pop. The caller must never push into a full buffer.
module fetch_fifo
    import if_fetch_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  fetch_entry_t push_entry,
    input  logic         pop,
    input  logic         flush,
    output fetch_entry_t head,
    output logic [1:0]   count
);

    fetch_entry_t entry0;
    fetch_entry_t entry1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            entry0 <= '0;
            entry1 <= '0;
            count  <= '0;
        end else if (flush) begin
            count <= '0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (count == 2'd0) entry0 <= push_entry;
                    else               entry1 <= push_entry;
                    count <= count + 2'd1;
                end
                2'b01: begin
                    entry0 <= entry1;
                    count  <= count - 2'd1;
                end
                2'b11: begin
                    // Simultaneous push/pop: the new word lands behind whatever remains.
                    if (count == 2'd1) begin
                        entry0 <= push_entry;
                    end else begin
                        entry0 <= entry1;
                        entry1 <= push_entry;
                    end
                end
                default: ;
            endcase
        end
    end

    assign head = entry0;

endmodule

// File: rtl/if_fetch.sv
// Instruction-fetch front end: PC, req/ack fetch FSM and branch redirect handling.
// Returned words are buffered in fetch_fifo and presented to if_to_id.
module if_fetch
    import if_fetch_pkg::*;
#(
    parameter logic [INST_ADDR_W-1:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned            FIFO_DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   stall,
    input  logic                   branch_flag,
    input  logic [INST_ADDR_W-1:0] branch_target,
    output logic                   imem_req,
    output logic [INST_ADDR_W-1:0] imem_addr,
    input  logic                   imem_ack,
    input  logic [INST_W-1:0]      imem_rdata,
    output logic                   if_valid,
    output logic [INST_ADDR_W-1:0] if_pc,
    output logic [INST_W-1:0]      if_inst
);

    localparam logic [1:0] FULL_COUNT = 2'(FIFO_DEPTH);

    fetch_state_t           state;
    fetch_state_t           state_nxt;
    logic [INST_ADDR_W-1:0] fetch_pc;
    logic [INST_ADDR_W-1:0] req_addr;
    logic [INST_ADDR_W-1:0] issue_addr;
    logic [1:0]             fifo_count;
    fetch_entry_t           head;
    fetch_entry_t           push_entry;
    logic                   fifo_valid;
    logic                   ack_taken;
    logic                   push;
    logic                   pop;
    logic                   unused_bits;

    assign unused_bits = ^{branch_target[1:0], issue_addr[1:0]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= FETCH_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            FETCH_IDLE:
                if (imem_req && !imem_ack)
                    state_nxt = branch_flag ? FETCH_DISCARD : FETCH_WAIT;
            FETCH_WAIT:
                if (imem_ack)         state_nxt = FETCH_IDLE;
                else if (branch_flag) state_nxt = FETCH_DISCARD;
            FETCH_DISCARD:
                if (imem_ack) state_nxt = FETCH_IDLE;
            default: state_nxt = FETCH_IDLE;
        endcase
    end

    // Space test uses the registered count, so a same-cycle pop never frees a slot.
    always_comb begin
        imem_req   = 1'b0;
        issue_addr = fetch_pc;
        case (state)
            FETCH_IDLE: begin
                imem_req   = (fifo_count < FULL_COUNT);
                issue_addr = fetch_pc;
            end
            FETCH_WAIT, FETCH_DISCARD: begin
                imem_req   = 1'b1;
                issue_addr = req_addr;
            end
            default: ;
        endcase
        if (rst) imem_req = 1'b0;
    end

    assign imem_addr  = {issue_addr[INST_ADDR_W-1:2], 2'b00};
    assign ack_taken  = imem_req && imem_ack;
    assign push       = ack_taken && (state != FETCH_DISCARD) && !branch_flag;
    assign push_entry = '{pc: imem_addr, inst: imem_rdata};
    assign fifo_valid = (fifo_count != 2'd0);
    assign pop        = fifo_valid && !stall && !branch_flag;

    assign if_valid = fifo_valid && !branch_flag;
    assign if_pc    = if_valid ? head.pc   : '0;
    assign if_inst  = if_valid ? head.inst : ZERO_WORD;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc <= RESET_PC;
            req_addr <= '0;
        end else begin
            if (branch_flag)
                fetch_pc <= {branch_target[INST_ADDR_W-1:2], 2'b00};
            else if (push)
                fetch_pc <= fetch_pc + PC_STEP;
            if (state == FETCH_IDLE && imem_req && !imem_ack)
                req_addr <= fetch_pc;
        end
    end

    fetch_fifo u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (push),
        .push_entry (push_entry),
        .pop        (pop),
        .flush      (branch_flag),
        .head       (head),
        .count      (fifo_count)
    );

endmodule

// File: doc/if_fetch.md
# if_fetch

Instruction-fetch front end: owns the program counter, issues word fetches to instruction memory over a req/ack handshake, and buffers returned words in a 2-entry FIFO. Drives `if_pc`/`if_inst` straight into `if_to_id`. Honours downstream stall and branch redirects from the decode stage. Memory latency is variable, and a fetch still in flight when a branch arrives is discarded.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC of the first fetch after reset.
- `FIFO_DEPTH`, default 2: fetch-buffer entries. Only 2 is supported.
- `clk`, input, 1: single clock, rising edge.
- `rst`, input, 1: reset, asynchronous, active-high (`rst_enable` = 1'b1).
- `stall`, input, 1: `if_to_id`/`id` cannot accept; hold the output entry.
- `branch_flag`, input, 1: one-cycle redirect pulse from `id`.
- `branch_target`, input, 32 (`inst_addr_bus`): redirect PC. Bits [1:0] are ignored.
- `imem_req`, output, 1: fetch request.
- `imem_addr`, output, 32: word-aligned fetch address. Bits [1:0] are always 0.
- `imem_ack`, input, 1: request accepted and `imem_rdata` valid this cycle.
- `imem_rdata`, input, 32 (`inst_bus`): fetched instruction.
- `if_valid`, output, 1: FIFO head is a real instruction.
- `if_pc`, output, 32: PC of FIFO head, or 0 when not valid.
- `if_inst`, output, 32: instruction at FIFO head, or 0 (nop) when not valid.

## Operation
- **Registers**
  - `fetch_pc`: next address to request.
  - `req_addr`: address of the outstanding request.
  - FIFO of {pc, inst}, with a 0..2 count.
  - FSM state.
- **FSM**
  - IDLE
    - Asserts `imem_req` with `imem_addr`=`fetch_pc` when count+0 < 2.
    - Ack in the same cycle: push {`fetch_pc`, `rdata`}; `fetch_pc` += 4; stay in IDLE.
    - Req without ack: `req_addr` <= `fetch_pc`; go to WAIT.
  - WAIT
    - `imem_req`=1 with `imem_addr`=`req_addr`, held stable until ack.
    - On ack: push; `fetch_pc` += 4; go to IDLE.
  - DISCARD
    - `imem_req`=1 with `imem_addr`=`req_addr`, held until ack.
    - On ack: drop the data; go to IDLE.
  - `imem_req` never deasserts before ack.
- **Space check**
  - Pushes can never overflow; this is guaranteed by the count test in IDLE.
  - A pop in the same cycle does not create space for a new request in that cycle. The test uses the registered count.
- **Pop**
  - Happens when `if_valid` && !`stall` && !`branch_flag`.
  - Push and pop in the same cycle leave the count unchanged.
- **Branch** (priority over stall, ack and pop)
  - FIFO flushed (count <= 0).
  - `fetch_pc` <= {`branch_target`[31:2], 2'b00}.
  - IDLE with req not acked: `req_addr` <= `fetch_pc`; go to DISCARD.
  - IDLE with ack in the same cycle: data dropped; stay in IDLE.
  - WAIT without ack: go to DISCARD.
  - WAIT with ack in the same cycle: data dropped; go to IDLE.
  - DISCARD: `fetch_pc` is updated to the new target; stay in DISCARD, or go to IDLE if acked.
  - There is no delay slot. Every instruction younger than the branch is killed.
- **Output forcing**
  - `if_valid`, `if_pc` and `if_inst` are forced to 0 in the `branch_flag` cycle, so `if_to_id` latches a bubble.
  - The same forcing applies whenever the FIFO is empty.
- **Arithmetic**
  - PC increment is 32-bit modulo: 32'hFFFF_FFFC + 4 = 32'h0000_0000.

## Timing
- **Reset** (asynchronous, takes effect immediately)
  - State IDLE; `fetch_pc`=`RESET_PC`; `req_addr`=0; count=0.
  - `imem_req`=0 while `rst`=1, gated combinationally.
  - `if_valid`=0, `if_pc`=0, `if_inst`=0.
- **First request**: `imem_req`=1 in the first cycle with `rst`=0.
- **Latency**
  - Ack in cycle N gives `if_valid`=1 with that word in cycle N+1.
  - With zero-wait memory: 1 instruction/cycle sustained when not stalled.
- **Stall**
  - Outputs hold their values.
  - Fetching continues until count=2, then `imem_req` drops in IDLE.
- **Reset mid-request**
  - The outstanding request is abandoned.
  - The memory side must tolerate `imem_req` falling without an ack.
- **Outputs**: `if_pc`/`if_inst` are registered FIFO outputs, gated by the combinational valid/branch mask.

## Structure
- `defines.v` holds:
  - `inst_addr_bus`, `inst_bus`, `rst_enable`, `zero_v`;
  - new `fetch_idle`/`fetch_wait`/`fetch_discard` 2-bit state encodings;
  - `pc_step` (32'd4).
- Sub-module `fetch_fifo`: 2-entry {pc, inst} FIFO with push, pop, flush and count, same clock and reset.
- `if_fetch` keeps the FSM and the PC logic.

## Test plan
- **Reset then zero-wait memory, no stall**
  - `imem_addr` 0, 4, 8 on consecutive cycles.
  - `if_pc` 0, 4, 8 one cycle after each ack.
  - `if_valid` stays 1.
- **Stall for 4 cycles from `if_pc`=4**
  - `if_pc`/`if_inst` hold at 4.
  - `imem_req` drops once count=2 (entries 4, 8).
  - After release, `if_pc` steps 8, 12 with no word lost or duplicated.
- **Branch with 3-cycle memory latency**
  - `branch_flag` with `branch_target`=32'h100 while WAIT at address 8.
  - State goes to DISCARD; `imem_addr` stays 8 until ack; that word never appears.
  - Next request is 32'h100; `if_valid`=0 in the branch cycle.
- **Branch and ack in the same cycle in IDLE, target 32'h203**
  - Acked word dropped; FIFO empty.
  - Next `imem_addr`=32'h200.
- **Wrap-around**
  - `RESET_PC`=32'hFFFF_FFF8.
  - Fetch addresses FFFF_FFF8, FFFF_FFFC, 0000_0000.
- **Reset mid-request**
  - `rst` pulse while WAIT.
  - `imem_req`=0 and `if_valid`=0 immediately.
  - After release, first fetch is `RESET_PC`.
